// File: rtl/cs_pkg.sv
// Shared types and helpers for the streaming cyclic-shift parity encoder.
package cs_pkg;

    // Widest symbol the rotate helper supports.
    localparam int MAX_W = 64;

    // One entry of the parity shift table: rotate-left amount, used mod WIDTH.
    typedef logic [7:0] shift_t;

    // Encoder phase: forwarding data symbols, or draining parity symbols.
    typedef enum logic {
        DATA   = 1'b0,
        PARITY = 1'b1
    } cs_enc_state_e;

    // Rotate the low 'width' bits of sym left by (amt mod width); upper bits are zero.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] sym,
                                              input shift_t           amt,
                                              input int               width);
        logic [MAX_W-1:0] r;
        int               a;
        int               j;
        r = '0;
        a = int'(amt) % width;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                j = (i + a) % width;
                r = r | ({{(MAX_W-1){1'b0}}, sym[i]} << j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_enc_stream_acc.sv
// Parity accumulator bank: one WIDTH-bit accumulator per parity symbol.
// Each accepted data symbol is rotated by its per-parity shift and XORed in.
module cs_parity_acc
    import cs_pkg::*;
#(
    parameter int M     = 2,
    parameter int K     = 3,
    parameter int WIDTH = 4,
    parameter int IDX_W = 1,
    parameter shift_t [K-M-1:0][M-1:0] SHIFT_TABLE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      update,
    input  logic [WIDTH-1:0]          sym,
    input  logic [IDX_W-1:0]          idx,
    output logic [K-M-1:0][WIDTH-1:0] acc
);

    logic [K-M-1:0][WIDTH-1:0] contrib;

    // Rotated contribution of the current symbol to every parity, selected by its position.
    always_comb begin
        contrib = '0;
        for (int p = 0; p < K - M; p++) begin
            for (int d = 0; d < M; d++) begin
                if (idx == IDX_W'(d)) begin
                    contrib[p] = WIDTH'(rotl(MAX_W'(sym), SHIFT_TABLE[p][d], WIDTH));
                end
            end
        end
    end

    // Accumulate on update; clear wins so a codeword boundary always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (update) begin
            acc <= acc ^ contrib;
        end
    end

endmodule

// File: rtl/cs_enc_stream.sv
// Streaming systematic cyclic-shift encoder. Data symbols pass straight through a
// single output register; after the M-th symbol the K-M parity symbols follow
// unless the codeword was flagged as bypass on its first symbol.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The output
// register is free when !out_valid || out_ready; it only loads when free and holds
// out_data/out_parity/out_last stable while out_valid && !out_ready. in_ready
// depends on state and out_ready only, never on in_valid.
module cs_enc_stream
    import cs_pkg::*;
#(
    parameter int M     = 2,
    parameter int K     = 3,
    parameter int WIDTH = 4,
    parameter shift_t [K-M-1:0][M-1:0] SHIFT_TABLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_last,
    output logic [15:0]      cw_count,
    output cs_enc_state_e    state
);

    localparam int P      = K - M;
    localparam int IDX_W  = (M > 1) ? $clog2(M) : 1;
    localparam int PIDX_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(M - 1);
    localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(P - 1);

    cs_enc_state_e         state_q;
    cs_enc_state_e         state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [PIDX_W-1:0]     pidx_q;
    logic                  bypass_q;
    logic                  out_free;
    logic                  accept;
    logic                  par_load;
    logic                  last_data;
    logic                  eff_bypass;
    logic                  acc_clear;
    logic                  acc_update;
    logic [P-1:0][WIDTH-1:0] acc;

    assign out_free   = !out_valid || out_ready;
    // On the first symbol the live input decides; later symbols use the latched flag.
    assign eff_bypass = (idx_q == '0) ? in_bypass : bypass_q;
    assign state      = state_q;

    // Next-state, handshake and accumulator control.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        accept     = 1'b0;
        par_load   = 1'b0;
        last_data  = 1'b0;
        acc_clear  = 1'b0;
        acc_update = 1'b0;
        case (state_q)
            DATA: begin
                in_ready = out_free;
                accept   = in_valid && out_free;
                if (accept) begin
                    if (idx_q == IDX_LAST) begin
                        if (eff_bypass) begin
                            last_data = 1'b1;
                            acc_clear = 1'b1;
                        end else begin
                            acc_update = 1'b1;
                            state_d    = PARITY;
                        end
                    end else begin
                        acc_update = 1'b1;
                    end
                end
            end
            PARITY: begin
                par_load = out_free;
                if (par_load && pidx_q == PIDX_LAST) begin
                    acc_clear = 1'b1;
                    state_d   = DATA;
                end
            end
            default: state_d = DATA;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Data and parity position counters plus the per-codeword bypass flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            pidx_q   <= '0;
            bypass_q <= 1'b0;
        end else begin
            if (accept) begin
                if (idx_q == '0) begin
                    bypass_q <= in_bypass;
                end
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            if (par_load) begin
                pidx_q <= (pidx_q == PIDX_LAST) ? '0 : pidx_q + 1'b1;
            end
        end
    end

    // Output register: loads a data or parity symbol when free, else drains on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_last   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
            out_parity <= 1'b0;
            out_last   <= last_data;
        end else if (par_load) begin
            out_valid  <= 1'b1;
            out_data   <= acc[pidx_q];
            out_parity <= 1'b1;
            out_last   <= (pidx_q == PIDX_LAST);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Count codewords whose last symbol has been handed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_count <= 16'd0;
        end else if (out_valid && out_ready && out_last) begin
            cw_count <= cw_count + 16'd1;
        end
    end

    cs_parity_acc #(
        .M          (M),
        .K          (K),
        .WIDTH      (WIDTH),
        .IDX_W      (IDX_W),
        .SHIFT_TABLE(SHIFT_TABLE)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .update(acc_update),
        .sym   (in_data),
        .idx   (idx_q),
        .acc   (acc)
    );

endmodule

// File: tb/tb_cs_enc_stream.sv
// Self-checking bench for cs_enc_stream: a narrow instance (M=2,K=3,W=4) and a
// wide instance (M=4,K=6,W=8), compared against a codeword-level reference model.
module tb_cs_enc_stream;
    import cs_pkg::*;

    localparam int AM = 2, AK = 3, AW = 4;
    localparam int BM = 4, BK = 6, BW = 8;
    localparam logic [AK-AM-1:0][AM-1:0][7:0] A_SH = {8'd1, 8'd0};
    localparam logic [BK-BM-1:0][BM-1:0][7:0] B_SH =
        {8'd6, 8'd4, 8'd2, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0};

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_in_valid, a_in_ready, a_in_bypass, a_out_valid, a_out_ready;
    logic          a_out_parity, a_out_last;
    logic [AW-1:0] a_in_data, a_out_data;
    logic [15:0]   a_cw_count;
    cs_enc_state_e a_state;

    logic          b_in_valid, b_in_ready, b_in_bypass, b_out_valid, b_out_ready;
    logic          b_out_parity, b_out_last;
    logic [BW-1:0] b_in_data, b_out_data;
    logic [15:0]   b_cw_count;
    cs_enc_state_e b_state;

    cs_enc_stream #(.M(AM), .K(AK), .WIDTH(AW), .SHIFT_TABLE(A_SH)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_bypass(a_in_bypass), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_parity(a_out_parity),
        .out_last(a_out_last), .cw_count(a_cw_count), .state(a_state)
    );

    cs_enc_stream #(.M(BM), .K(BK), .WIDTH(BW), .SHIFT_TABLE(B_SH)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_bypass(b_in_bypass), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_parity(b_out_parity),
        .out_last(b_out_last), .cw_count(b_cw_count), .state(b_state)
    );

    // scoreboard: items are {last, parity, data}
    logic [AW+1:0] a_exp_q[$];
    logic [AW+1:0] a_obs_q[$];
    logic [AW:0]   a_in_q[$];
    logic [BW+1:0] b_exp_q[$];
    logic [BW+1:0] b_obs_q[$];
    logic [BW:0]   b_in_q[$];
    int a_cw_exp = 0;
    int b_cw_exp = 0;
    int tests_run = 0;
    int tests_failed = 0;

    // output monitors: a handshake seen at negedge completes on the next rising edge
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready)
            a_obs_q.push_back({a_out_last, a_out_parity, a_out_data});
        if (!rst && b_out_valid && b_out_ready)
            b_obs_q.push_back({b_out_last, b_out_parity, b_out_data});
    end

    // reference rotate: shift into a double-width word and fold the overflow back
    function automatic logic [7:0] ref_rotl(input logic [7:0] x, input int amt, input int w);
        int          a;
        logic [15:0] dbl;
        logic [7:0]  mask;
        a    = amt % w;
        dbl  = {8'd0, x} << a;
        mask = 8'((16'd1 << w) - 16'd1);
        return (dbl[7:0] | 8'(dbl >> w)) & mask;
    endfunction

    // model: one codeword for the narrow instance (syms[AW-1:0] is the first symbol)
    task automatic a_add_cw(input logic [AM*AW-1:0] syms, input bit byp);
        logic [AW-1:0] par [AK-AM];
        logic [AW-1:0] s;
        bit            bb;
        for (int p = 0; p < AK - AM; p++) par[p] = '0;
        for (int d = 0; d < AM; d++) begin
            s  = syms[d*AW +: AW];
            bb = (d == 0) ? byp : 1'($urandom_range(1));
            a_in_q.push_back({bb, s});
            a_exp_q.push_back({(byp && (d == AM - 1)), 1'b0, s});
            for (int p = 0; p < AK - AM; p++)
                par[p] = par[p] ^ AW'(ref_rotl(8'(s), int'(A_SH[p][d]), AW));
        end
        if (!byp)
            for (int p = 0; p < AK - AM; p++)
                a_exp_q.push_back({(p == AK - AM - 1), 1'b1, par[p]});
        a_cw_exp++;
    endtask

    task automatic b_add_cw(input logic [BM*BW-1:0] syms, input bit byp);
        logic [BW-1:0] par [BK-BM];
        logic [BW-1:0] s;
        bit            bb;
        for (int p = 0; p < BK - BM; p++) par[p] = '0;
        for (int d = 0; d < BM; d++) begin
            s  = syms[d*BW +: BW];
            bb = (d == 0) ? byp : 1'($urandom_range(1));
            b_in_q.push_back({bb, s});
            b_exp_q.push_back({(byp && (d == BM - 1)), 1'b0, s});
            for (int p = 0; p < BK - BM; p++)
                par[p] = par[p] ^ ref_rotl(s, int'(B_SH[p][d]), BW);
        end
        if (!byp)
            for (int p = 0; p < BK - BM; p++)
                b_exp_q.push_back({(p == BK - BM - 1), 1'b1, par[p]});
        b_cw_exp++;
    endtask

    // driver: stream a_in_q with random out_ready until all expected outputs seen
    task automatic a_run(input int ready_pct, input int budget, output int cycles, output int stalls);
        bit acc;
        cycles = 0;
        stalls = 0;
        while ((a_in_q.size() > 0 || a_obs_q.size() < a_exp_q.size()) && cycles < budget) begin
            a_in_valid = (a_in_q.size() > 0);
            if (a_in_valid) {a_in_bypass, a_in_data} = a_in_q[0];
            else begin a_in_bypass = 1'b0; a_in_data = '0; end
            a_out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (a_in_valid && !a_in_ready) stalls++;
            @(posedge clk); #1;
            if (acc) void'(a_in_q.pop_front());
            cycles++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
    endtask

    task automatic b_run(input int ready_pct, input int budget, output int cycles);
        bit acc;
        cycles = 0;
        while ((b_in_q.size() > 0 || b_obs_q.size() < b_exp_q.size()) && cycles < budget) begin
            b_in_valid = (b_in_q.size() > 0);
            if (b_in_valid) {b_in_bypass, b_in_data} = b_in_q[0];
            else begin b_in_bypass = 1'b0; b_in_data = '0; end
            b_out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            @(posedge clk); #1;
            if (acc) void'(b_in_q.pop_front());
            cycles++;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
    endtask

    task automatic clear_a();
        a_exp_q.delete(); a_obs_q.delete(); a_in_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_in_bypass = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_bypass = 0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({a_out_valid, a_out_data, a_out_parity, a_out_last} !== '0) begin
            tests_failed++;
            $display("FAIL reset_a_out: got v=%b d=%h p=%b l=%b, want all 0",
                     a_out_valid, a_out_data, a_out_parity, a_out_last);
        end
        tests_run++;
        if (a_cw_count !== 16'd0 || b_cw_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_cw_count: got a=%0d b=%0d, want 0", a_cw_count, b_cw_count);
        end
        tests_run++;
        if (a_in_ready !== 1'b1 || a_state !== DATA) begin
            tests_failed++;
            $display("FAIL reset_ready_state: got ready=%b state=%0d, want ready=1 state=DATA",
                     a_in_ready, a_state);
        end
        tests_run++;
        if ({b_out_valid, b_out_data, b_out_parity, b_out_last} !== '0) begin
            tests_failed++;
            $display("FAIL reset_b_out: got v=%b d=%h, want 0", b_out_valid, b_out_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc, st;
        clear_a();
        a_add_cw({4'h5, 4'h3}, 1'b0);
        a_run(100, 50, cyc, st);
        tests_run++;
        if (a_obs_q.size() != 3 || a_exp_q.size() != 3) begin
            tests_failed++;
            $display("FAIL basic_len: got %0d items, want 3", a_obs_q.size());
        end
        for (int i = 0; i < a_exp_q.size() && i < a_obs_q.size(); i++) begin
            tests_run++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_item%0d: got %h, want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
        tests_run++;
        if (a_obs_q.size() < 3 || a_obs_q[2] !== 6'b11_1001) begin
            tests_failed++;
            $display("FAIL basic_parity: got %h, want 39 (last,parity,0x9)",
                     (a_obs_q.size() > 2) ? a_obs_q[2] : 6'h0);
        end
        tests_run++;
        if (cyc != AK + 1) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles, want %0d", cyc, AK + 1);
        end
        tests_run++;
        if (a_cw_count !== 16'(a_cw_exp)) begin
            tests_failed++;
            $display("FAIL basic_cw_count: got %0d, want %0d", a_cw_count, a_cw_exp);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, st;
        clear_a();
        a_add_cw({4'h5, 4'h3}, 1'b0);
        a_add_cw({4'h1, 4'h1}, 1'b0);
        a_run(100, 50, cyc, st);
        tests_run++;
        if (a_obs_q.size() != 6) begin
            tests_failed++;
            $display("FAIL b2b_len: got %0d items, want 6", a_obs_q.size());
        end
        for (int i = 0; i < a_exp_q.size() && i < a_obs_q.size(); i++) begin
            tests_run++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_item%0d: got %h, want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
        tests_run++;
        if (cyc != 7 || st != 1) begin
            tests_failed++;
            $display("FAIL b2b_timing: got cycles=%0d stalls=%0d, want cycles=7 stalls=1", cyc, st);
        end
        tests_run++;
        if (a_cw_count !== 16'(a_cw_exp)) begin
            tests_failed++;
            $display("FAIL b2b_cw_count: got %0d, want %0d", a_cw_count, a_cw_exp);
        end
    endtask

    task automatic test_bypass();
        int cyc, st;
        clear_a();
        a_add_cw({4'h5, 4'h3}, 1'b1);
        a_add_cw({4'h5, 4'h3}, 1'b0);
        a_run(100, 50, cyc, st);
        tests_run++;
        if (a_obs_q.size() != 5) begin
            tests_failed++;
            $display("FAIL bypass_len: got %0d items, want 5", a_obs_q.size());
        end
        for (int i = 0; i < a_exp_q.size() && i < a_obs_q.size(); i++) begin
            tests_run++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                tests_failed++;
                $display("FAIL bypass_item%0d: got %h, want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
        tests_run++;
        if (a_cw_count !== 16'(a_cw_exp)) begin
            tests_failed++;
            $display("FAIL bypass_cw_count: got %0d, want %0d", a_cw_count, a_cw_exp);
        end
    endtask

    task automatic test_backpressure();
        int n_par;
        clear_a();
        a_out_ready = 1; a_in_bypass = 0;
        a_in_valid = 1; a_in_data = 4'h3; @(posedge clk); #1;
        a_in_data = 4'h5; @(posedge clk); #1;
        a_in_valid = 0; @(posedge clk); #1;
        a_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (a_out_valid !== 1'b1 || a_out_data !== 4'h9 || a_out_last !== 1'b1 ||
                a_out_parity !== 1'b1 || a_in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got v=%b d=%h l=%b p=%b rdy=%b, want v=1 d=9 l=1 p=1 rdy=0",
                         i, a_out_valid, a_out_data, a_out_last, a_out_parity, a_in_ready);
            end
            @(posedge clk); #1;
        end
        a_out_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (a_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_drain: got out_valid=%b, want 0", a_out_valid);
        end
        n_par = 0;
        foreach (a_obs_q[i]) if (a_obs_q[i] === 6'b11_1001) n_par++;
        tests_run++;
        if (n_par != 1 || a_obs_q.size() != 3) begin
            tests_failed++;
            $display("FAIL stall_once: got %0d parity of %0d items, want 1 of 3", n_par, a_obs_q.size());
        end
        a_cw_exp++;
        tests_run++;
        if (a_cw_count !== 16'(a_cw_exp)) begin
            tests_failed++;
            $display("FAIL stall_cw_count: got %0d, want %0d", a_cw_count, a_cw_exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc, st;
        a_out_ready = 1; a_in_bypass = 0;
        a_in_valid = 1; a_in_data = 4'h3; @(posedge clk); #1;
        a_in_valid = 0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({a_out_valid, a_out_data, a_out_parity, a_out_last} !== '0 || a_cw_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid_out: got v=%b d=%h p=%b l=%b cw=%0d, want all 0",
                     a_out_valid, a_out_data, a_out_parity, a_out_last, a_cw_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        a_cw_exp = 0;
        b_cw_exp = 0;
        clear_a();
        a_add_cw({4'h1, 4'h1}, 1'b0);
        a_run(100, 50, cyc, st);
        tests_run++;
        if (a_obs_q.size() != 3 || a_obs_q[2] !== 6'b11_0011) begin
            tests_failed++;
            $display("FAIL rstmid_parity: got %0d items last=%h, want 3 items last=33",
                     a_obs_q.size(), (a_obs_q.size() > 0) ? a_obs_q[a_obs_q.size()-1] : 6'h0);
        end
        tests_run++;
        if (a_cw_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL rstmid_cw_count: got %0d, want 1", a_cw_count);
        end
    endtask

    task automatic test_random_narrow();
        int cyc, st;
        clear_a();
        for (int i = 0; i < 10; i++)
            a_add_cw(8'($urandom), ($urandom_range(3) == 0));
        a_run(60, 500, cyc, st);
        tests_run++;
        if (a_obs_q.size() != a_exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_a_len: got %0d items, want %0d", a_obs_q.size(), a_exp_q.size());
        end
        for (int i = 0; i < a_exp_q.size() && i < a_obs_q.size(); i++) begin
            tests_run++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                tests_failed++;
                $display("FAIL rand_a_item%0d: got %h, want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
        tests_run++;
        if (a_cw_count !== 16'(a_cw_exp)) begin
            tests_failed++;
            $display("FAIL rand_a_cw_count: got %0d, want %0d", a_cw_count, a_cw_exp);
        end
    endtask

    task automatic test_wide();
        int cyc;
        b_exp_q.delete(); b_obs_q.delete(); b_in_q.delete();
        b_add_cw(32'h01010101, 1'b0);
        b_run(100, 50, cyc);
        tests_run++;
        if (b_obs_q.size() != 6 || b_obs_q[4] !== 10'b01_0000_1111 || b_obs_q[5] !== 10'b11_0101_0101) begin
            tests_failed++;
            $display("FAIL wide_fixed: got %0d items, p0=%h p1=%h, want 6 items p0=10f p1=355",
                     b_obs_q.size(), (b_obs_q.size() > 5) ? b_obs_q[4] : 10'h0,
                     (b_obs_q.size() > 5) ? b_obs_q[5] : 10'h0);
        end
        tests_run++;
        if (cyc != BK + 1) begin
            tests_failed++;
            $display("FAIL wide_latency: got %0d cycles, want %0d", cyc, BK + 1);
        end
        b_exp_q.delete(); b_obs_q.delete(); b_in_q.delete();
        for (int i = 0; i < 8; i++)
            b_add_cw($urandom, ($urandom_range(3) == 0));
        b_run(50, 800, cyc);
        tests_run++;
        if (b_obs_q.size() != b_exp_q.size()) begin
            tests_failed++;
            $display("FAIL wide_len: got %0d items, want %0d", b_obs_q.size(), b_exp_q.size());
        end
        for (int i = 0; i < b_exp_q.size() && i < b_obs_q.size(); i++) begin
            tests_run++;
            if (b_obs_q[i] !== b_exp_q[i]) begin
                tests_failed++;
                $display("FAIL wide_item%0d: got %h, want %h", i, b_obs_q[i], b_exp_q[i]);
            end
        end
        tests_run++;
        if (b_cw_count !== 16'(b_cw_exp)) begin
            tests_failed++;
            $display("FAIL wide_cw_count: got %0d, want %0d", b_cw_count, b_cw_exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_random_narrow();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
